// File: rtl/fas_pkg.sv
// Shared frequency-analysis constants, read-side states and index helpers.
// Reused by the FFT stage, so keep it free of block-specific state.
package fas_pkg;

  localparam int N  = 32;
  localparam int DW = 16;
  localparam int AW = 5;

  typedef enum logic {
    R_IDLE,
    R_SEND
  } rd_state_e;

  function automatic logic [AW-1:0] bitrev(
    input logic [AW-1:0] a
  );
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) begin
      r[i] = a[AW-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_bank.sv
// One frame of sample storage: synchronous write, asynchronous read.
// Contents are deliberately left unreset.
module frame_bank
  import fas_pkg::*;
#(
  parameter int BDW = DW,
  parameter int BN  = N,
  parameter int BAW = AW
) (
  input  logic           clk,
  input  logic           we,
  input  logic [BAW-1:0] waddr,
  input  logic [BDW-1:0] wdata,
  input  logic [BAW-1:0] raddr,
  output logic [BDW-1:0] rdata
);

  logic [BDW-1:0] mem [BN];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fir_frame_collector.sv
// Double-buffered FIR frame capture with bit-reversed replay to the FFT.
// A frame landing on a still-occupied bank is dropped whole and flagged.
module fir_frame_collector
  import fas_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          fir_valid,
  input  logic [DW-1:0] fir_d,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_idx,
  output logic          out_last,
  output logic          overrun
);

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic          drop_q, drop_d;
  logic          overrun_q, overrun_d;
  logic [1:0]    full_q, full_d;
  rd_state_e     state_q, state_d;

  logic          first_w, last_w, free_w;
  logic          chk_drop, drop_now, we;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] raddr;

  always_comb begin
    first_w  = fir_valid && (wr_cnt_q == '0);
    last_w   = fir_valid && (wr_cnt_q == LAST);
    free_w   = (state_q == R_SEND) && out_ready
               && (rd_cnt_q == LAST);
    // A bank released on this edge may take the new frame.
    chk_drop = full_q[wr_bank_q]
               && !(free_w && (rd_bank_q == wr_bank_q));
    drop_now = first_w ? chk_drop : drop_q;
    we       = fir_valid && !drop_now;
    raddr    = bitrev(rd_cnt_q);
  end

  always_comb begin
    wr_cnt_d  = fir_valid ? wr_cnt_q + 1'b1 : wr_cnt_q;
    drop_d    = drop_q;
    if (first_w) drop_d = chk_drop;
    if (last_w)  drop_d = 1'b0;
    overrun_d = first_w && chk_drop;
    wr_bank_d = wr_bank_q ^ (last_w && !drop_now);
    rd_bank_d = rd_bank_q ^ free_w;
    full_d    = full_q;
    if (free_w) full_d[rd_bank_q] = 1'b0;
    if (last_w && !drop_now) full_d[wr_bank_q] = 1'b1;
    rd_cnt_d  = rd_cnt_q;
    if ((state_q == R_SEND) && out_ready) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      R_IDLE: if (full_q[rd_bank_q]) state_d = R_SEND;
      R_SEND: if (free_w) state_d = R_IDLE;
      default: state_d = R_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == R_SEND);
    out_idx   = out_valid ? rd_cnt_q : '0;
    out_last  = out_valid && (rd_cnt_q == LAST);
    out_data  = '0;
    if (out_valid) out_data = rd_bank_q ? rdata1 : rdata0;
    overrun   = overrun_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      drop_q    <= 1'b0;
      overrun_q <= 1'b0;
      full_q    <= 2'b00;
      state_q   <= R_IDLE;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      drop_q    <= drop_d;
      overrun_q <= overrun_d;
      full_q    <= full_d;
      state_q   <= state_d;
    end
  end

  frame_bank u_bank0 (
    .clk   (clk),
    .we    (we && !wr_bank_q),
    .waddr (wr_cnt_q),
    .wdata (fir_d),
    .raddr (raddr),
    .rdata (rdata0)
  );

  frame_bank u_bank1 (
    .clk   (clk),
    .we    (we && wr_bank_q),
    .waddr (wr_cnt_q),
    .wdata (fir_d),
    .raddr (raddr),
    .rdata (rdata1)
  );

endmodule

// File: tb/tb_fir_frame_collector.sv
// Directed bench for fir_frame_collector: capture, bit-reversed replay,
// backpressure, double buffering, overrun and reset behaviour.
module tb_fir_frame_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fir_valid = 1'b0;
  logic [15:0] fir_d = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [4:0]  out_idx;
  logic        out_last;
  logic        overrun;

  int checks = 0;
  int failures = 0;
  int q_data[$];
  int q_idx[$];
  int q_last[$];
  int ovr_cnt = 0;
  int hold_err = 0;

  logic        pst = 1'b0;
  logic [15:0] pd = '0;
  logic [4:0]  pi = '0;
  logic        pl = 1'b0;

  fir_frame_collector dut (
    .clk       (clk),
    .rst       (rst),
    .fir_valid (fir_valid),
    .fir_d     (fir_d),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        q_data.push_back(int'(out_data));
        q_idx.push_back(int'(out_idx));
        q_last.push_back(int'(out_last));
      end
      if (overrun) ovr_cnt++;
      if (pst && (!out_valid || out_data !== pd
          || out_idx !== pi || out_last !== pl))
        hold_err++;
    end
    pst = out_valid && !out_ready;
    pd  = out_data;
    pi  = out_idx;
    pl  = out_last;
  end

  function automatic int rev5(input int k);
    int r;
    r = 0;
    for (int b = 0; b < 5; b++) begin
      if ((k >> b) & 1) r = r | (1 << (4 - b));
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      fir_valid = 1'b1;
      fir_d = 16'(base + i);
      tick();
    end
    fir_valid = 1'b0;
  endtask

  task automatic wait_n(input int n, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (q_data.size() >= n) break;
      tick();
    end
  endtask

  task automatic clr();
    q_data.delete();
    q_idx.delete();
    q_last.delete();
    ovr_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'd0 || out_idx !== 5'd0
        || out_last !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: v=%b d=%0d i=%0d l=%b o=%b want all 0",
               out_valid, out_data, out_idx, out_last, overrun);
    end
    rst = 1'b0;
    tick();
    out_ready = 1'b0;
    send(7, 32);
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_valid: got %b want 1", out_valid);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'd0 || out_idx !== 5'd0
        || out_last !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: v=%b d=%0d i=%0d l=%b o=%b want all 0",
               out_valid, out_data, out_idx, out_last, overrun);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    clr();
    out_ready = 1'b1;
    repeat (40) tick();
    checks++;
    if (q_data.size() !== 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_output: got %0d words want 0",
               q_data.size());
    end
  endtask

  task automatic test_single();
    clr();
    out_ready = 1'b1;
    send(0, 32);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_early: valid %b want 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL latency_rise: valid %b want 1", out_valid);
    end
    wait_n(32, 100);
    checks++;
    if (q_data.size() != 32) begin
      failures++;
      $display("FAIL single_count: got %0d want 32", q_data.size());
    end
    for (int k = 0; k < 32 && k < q_data.size(); k++) begin
      checks++;
      if (q_data[k] !== rev5(k) || q_idx[k] !== k
          || q_last[k] !== int'(k == 31)) begin
        failures++;
        $display("FAIL single_word %0d: d=%0d i=%0d l=%0d want %0d %0d %0d",
                 k, q_data[k], q_idx[k], q_last[k], rev5(k), k, k == 31);
      end
    end
    if (q_data.size() > 3) begin
      checks++;
      if (q_data[1] !== 16 || q_data[3] !== 24) begin
        failures++;
        $display("FAIL bitrev_ref: got %0d,%0d want 16,24",
                 q_data[1], q_data[3]);
      end
    end
    repeat (4) tick();
  endtask

  task automatic test_backpressure();
    clr();
    out_ready = 1'b0;
    send(0, 32);
    hold_err = 0;
    for (int c = 0; c < 400; c++) begin
      if (q_data.size() >= 32) break;
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      tick();
    end
    out_ready = 1'b1;
    repeat (4) tick();
    checks++;
    if (q_data.size() != 32) begin
      failures++;
      $display("FAIL bp_count: got %0d want 32", q_data.size());
    end
    for (int k = 0; k < 32 && k < q_data.size(); k++) begin
      checks++;
      if (q_data[k] !== rev5(k) || q_idx[k] !== k
          || q_last[k] !== int'(k == 31)) begin
        failures++;
        $display("FAIL bp_word %0d: d=%0d i=%0d want %0d %0d",
                 k, q_data[k], q_idx[k], rev5(k), k);
      end
    end
    checks++;
    if (hold_err !== 0) begin
      failures++;
      $display("FAIL bp_hold: %0d unstable stalls want 0", hold_err);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    clr();
    out_ready = 1'b1;
    send(0, 32);
    send(100, 32);
    wait_n(64, 300);
    repeat (40) tick();
    checks++;
    if (q_data.size() != 64) begin
      failures++;
      $display("FAIL b2b_count: got %0d want 64", q_data.size());
    end
    for (int k = 0; k < 64 && k < q_data.size(); k++) begin
      base = (k < 32) ? 0 : 100;
      checks++;
      if (q_data[k] !== base + rev5(k % 32) || q_idx[k] !== k % 32
          || q_last[k] !== int'(k % 32 == 31)) begin
        failures++;
        $display("FAIL b2b_word %0d: d=%0d i=%0d want %0d %0d",
                 k, q_data[k], q_idx[k], base + rev5(k % 32), k % 32);
      end
    end
    checks++;
    if (ovr_cnt !== 0) begin
      failures++;
      $display("FAIL b2b_overrun: got %0d pulses want 0", ovr_cnt);
    end
  endtask

  task automatic test_overrun();
    int base;
    clr();
    out_ready = 1'b0;
    send(0, 32);
    send(100, 32);
    for (int i = 0; i < 32; i++) begin
      fir_valid = 1'b1;
      fir_d = 16'(300 + i);
      tick();
      if (i == 0) begin
        checks++;
        if (overrun !== 1'b1) begin
          failures++;
          $display("FAIL ovr_pulse: got %b want 1", overrun);
        end
      end
      if (i == 1) begin
        checks++;
        if (overrun !== 1'b0) begin
          failures++;
          $display("FAIL ovr_width: got %b want 0", overrun);
        end
      end
    end
    fir_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    wait_n(64, 300);
    repeat (40) tick();
    checks++;
    if (ovr_cnt !== 1) begin
      failures++;
      $display("FAIL ovr_count: got %0d pulses want 1", ovr_cnt);
    end
    checks++;
    if (q_data.size() != 64) begin
      failures++;
      $display("FAIL ovr_words: got %0d want 64", q_data.size());
    end
    for (int k = 0; k < 64 && k < q_data.size(); k++) begin
      base = (k < 32) ? 0 : 100;
      checks++;
      if (q_data[k] !== base + rev5(k % 32) || q_idx[k] !== k % 32) begin
        failures++;
        $display("FAIL ovr_word %0d: d=%0d i=%0d want %0d %0d",
                 k, q_data[k], q_idx[k], base + rev5(k % 32), k % 32);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    clr();
    out_ready = 1'b1;
    send(50, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    send(200, 32);
    wait_n(32, 100);
    repeat (40) tick();
    checks++;
    if (q_data.size() != 32) begin
      failures++;
      $display("FAIL rmf_count: got %0d want 32", q_data.size());
    end
    for (int k = 0; k < 32 && k < q_data.size(); k++) begin
      checks++;
      if (q_data[k] !== 200 + rev5(k) || q_idx[k] !== k) begin
        failures++;
        $display("FAIL rmf_word %0d: d=%0d i=%0d want %0d %0d",
                 k, q_data[k], q_idx[k], 200 + rev5(k), k);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
